lcd_line_writer: RTL and testbench
==================================

# lcd_line_writer

Downstream consumer of the `dual2ascii` converter in the bike-computer display path. Captures each six-character ASCII frame (2 upper-line, 4 lower-line characters) on `valid_out`. Serialises the frame as LCD set-address commands plus character writes over a valid/ready byte interface to the LCD bus driver. Lines identical to what was last written are skipped, and one frame arriving while busy is buffered.

## Interface
- `UPPER_POS`, default 7'h0E: DDRAM address of the first upper-line character.
- `LOWER_POS`, default 7'h4C: DDRAM address of the first lower-line character.
- `clock` in 1: single system clock, rising edge.
- `reset` in 1: asynchronous, active-high.
- `valid_out` in 1: frame-valid pulse from `dual2ascii`.
- `upper10`, `upper01` in 8 each: upper-line characters, left to right.
- `lower1000`, `lower0100`, `lower0010`, `lower0001` in 8 each: lower-line characters, left to right.
- `lcd_data` out 8: command or character byte.
- `lcd_rs` out 1: 0 = command, 1 = character data.
- `lcd_valid` out 1: byte offered.
- `lcd_ready` in 1: driver accepts the byte.
- `busy` out 1: high in every state except IDLE.
- `frame_done` out 1: one-cycle pulse at the end of each accepted frame.
- `overrun` out 1: one-cycle pulse when a buffered frame is discarded without being sent.

## Operation
- States: IDLE, LOAD, U_CMD, U_CH, L_CMD, L_CH, DONE.
- IDLE:
  - if `pending`: copy the pending buffer to the shadow register, clear `pending`, go to LOAD.
  - else if `valid_out`: copy the input bytes to the shadow register, go to LOAD.
  - if `pending` and `valid_out` are both high: the input wins, the pending frame is discarded and `overrun` pulses.
- LOAD: compare each shadow line against the last-written copy to set `dirty_u` and `dirty_l`. Next state: U_CMD if `dirty_u`, else L_CMD if `dirty_l`, else DONE.
- U_CMD: send 0x80|UPPER_POS with rs=0, then go to U_CH.
- U_CH: send `upper10`, then `upper01` (rs=1). Then go to L_CMD if `dirty_l`, else DONE.
- L_CMD: send 0x80|LOWER_POS with rs=0, then go to L_CH.
- L_CH: send `lower1000`, `lower0100`, `lower0010`, `lower0001` (rs=1), then go to DONE.
- A 2-bit character index counts the bytes within a CH state.
- The last-written copy of a line updates only when that line's final character transfers.
- DONE: assert `frame_done`; go to IDLE.
- `valid_out` in any state other than IDLE stores the inputs into the one-deep pending buffer and sets `pending`. If `pending` was already set, the old buffer is overwritten and `overrun` pulses.
- After reset a `force_all` flag is set: both lines count as dirty for the first frame. The flag clears when that frame reaches DONE.

## Timing
- Reset values:
  - outputs: `lcd_data`=0, `lcd_rs`=0, `lcd_valid`=0, `busy`=0, `frame_done`=0, `overrun`=0.
  - internal: state=IDLE, `pending`=0, `force_all`=1, last-written copies=0.
- `lcd_valid`, `lcd_rs` and `lcd_data` are registered outputs.
- A transfer occurs on a rising edge where `lcd_valid` and `lcd_ready` are both 1. `lcd_data` and `lcd_rs` stay stable while `lcd_valid`=1 and `lcd_ready`=0.
- Transfers are back-to-back: the next byte is offered in the cycle after an accepted transfer.
- Frame latency with `valid_out` high in cycle 0 and `lcd_ready` held at 1:
  - cycle 1: LOAD.
  - cycles 2–9: the 8 transfers.
  - cycle 10: DONE, `frame_done`=1.
  - cycle 11: IDLE.
- Only one line dirty: 3 or 5 transfers, and DONE follows the last transfer directly.
- Neither line dirty: `frame_done` in cycle 2 with no transfer.
- A `valid_out` arriving in cycles 1–10 goes to the pending buffer; the next frame then starts LOAD at cycle 12.
- Reset asserted mid-frame: all outputs and state return to reset values immediately and the pending frame is lost. No `overrun` pulse is generated.

## Structure
- Shared package `bike_lcd_pkg`, holding:
  - the state enum;
  - `LCD_SET_DDRAM` = 8'h80;
  - `RS_CMD`=0 and `RS_DATA`=1;
  - `FRAME_CHARS`=6.
- Single module; no sub-module. The line-compare and shadow logic is small enough to stay inline.

## Test plan
- **Full first frame.** After reset, `valid_out` with upper "69", lower "1920", `lcd_ready`=1.
  - Bytes in order: 0x8E rs0, 0x36, 0x39, 0xCC rs0, 0x31, 0x39, 0x32, 0x30.
  - `frame_done` in cycle 10.
- **Identical frame.** Repeat the same frame: no `lcd_valid`; `frame_done` in cycle 2.
- **One line changed.** Change only the lower line to "2030": bytes 0xCC, 0x32, 0x30, 0x33, 0x30; `frame_done` one cycle after the last transfer.
- **Backpressure.** Hold `lcd_ready`=0 for 3 cycles while 0x36 is offered: `lcd_data`=0x36 and `lcd_valid`=1 stay stable, and the frame completes 3 cycles late.
- **Overrun.** Three `valid_out` pulses during a busy frame: `overrun` pulses twice, and only the third frame is written next.
- **Reset mid-frame.** Assert `reset` during L_CH: outputs go to 0 immediately. Re-sending the identical frame afterwards rewrites both lines (8 transfers).

Source files
------------

// File: rtl/bike_lcd_pkg.sv
// Shared definitions for the bike-computer LCD display path.
//   lcd_state_t    : line-writer sequencer states
//   LCD_SET_DDRAM  : HD44780-style "set DDRAM address" command base
//   RS_CMD/RS_DATA : register-select values for command / character bytes
//   FRAME_CHARS    : characters per frame (2 upper + 4 lower)
package bike_lcd_pkg;

    typedef enum logic [2:0] {
        IDLE  = 3'd0,
        LOAD  = 3'd1,
        U_CMD = 3'd2,
        U_CH  = 3'd3,
        L_CMD = 3'd4,
        L_CH  = 3'd5,
        DONE  = 3'd6
    } lcd_state_t;

    localparam logic [7:0]  LCD_SET_DDRAM = 8'h80;
    localparam logic        RS_CMD        = 1'b0;
    localparam logic        RS_DATA       = 1'b1;
    localparam int unsigned FRAME_CHARS   = 6;

    // Set-address command byte for a 7-bit DDRAM position.
    function automatic logic [7:0] ddram_cmd(input logic [6:0] pos);
        return LCD_SET_DDRAM | {1'b0, pos};
    endfunction

endpackage

// File: rtl/lcd_line_writer.sv
// Captures six-character ASCII frames from dual2ascii and writes them to the
// LCD as set-address commands plus character bytes over a valid/ready link.
// Lines unchanged since their last write are skipped; one frame arriving
// while busy is held in a pending buffer.
//
// Ports:
//   clock, reset          : system clock, asynchronous active-high reset
//   valid_out             : frame-valid pulse from dual2ascii
//   upper10, upper01      : upper-line characters, left to right
//   lower1000..lower0001  : lower-line characters, left to right
//   lcd_data, lcd_rs      : byte to LCD driver, 0 = command / 1 = character
//   lcd_valid, lcd_ready  : byte handshake
//   busy                  : sequencer not idle
//   frame_done            : one-cycle pulse at end of each accepted frame
//   overrun               : one-cycle pulse when a buffered frame is dropped
module lcd_line_writer
    import bike_lcd_pkg::*;
#(
    parameter logic [6:0] UPPER_POS = 7'h0E,
    parameter logic [6:0] LOWER_POS = 7'h4C
) (
    input  logic       clock,
    input  logic       reset,
    input  logic       valid_out,
    input  logic [7:0] upper10,
    input  logic [7:0] upper01,
    input  logic [7:0] lower1000,
    input  logic [7:0] lower0100,
    input  logic [7:0] lower0010,
    input  logic [7:0] lower0001,
    output logic [7:0] lcd_data,
    output logic       lcd_rs,
    output logic       lcd_valid,
    input  logic       lcd_ready,
    output logic       busy,
    output logic       frame_done,
    output logic       overrun
);

    localparam logic [7:0] CMD_UPPER = ddram_cmd(UPPER_POS);
    localparam logic [7:0] CMD_LOWER = ddram_cmd(LOWER_POS);

    lcd_state_t  state;
    logic [7:0]  frame_in [FRAME_CHARS];
    logic [7:0]  shadow   [FRAME_CHARS];
    logic [7:0]  pend_buf [FRAME_CHARS];
    logic        pending;
    logic        force_all;
    logic        dirty_l;
    logic [1:0]  char_idx;
    logic [15:0] last_u;
    logic [31:0] last_l;
    logic        load_dirty_u;
    logic        load_dirty_l;
    logic        accepted;

    always_comb begin
        frame_in[0] = upper10;
        frame_in[1] = upper01;
        frame_in[2] = lower1000;
        frame_in[3] = lower0100;
        frame_in[4] = lower0010;
        frame_in[5] = lower0001;
    end

    assign load_dirty_u = force_all || ({shadow[0], shadow[1]} != last_u);
    assign load_dirty_l = force_all ||
                          ({shadow[2], shadow[3], shadow[4], shadow[5]} != last_l);
    assign accepted     = lcd_valid && lcd_ready;
    assign busy         = (state != IDLE);

    // Outputs are loaded on the transition into the state that offers them,
    // so each byte is presented in the first cycle of its state and the next
    // byte follows immediately after an accepted transfer.
    always_ff @(posedge clock or posedge reset) begin
        if (reset) begin
            state      <= IDLE;
            lcd_data   <= '0;
            lcd_rs     <= RS_CMD;
            lcd_valid  <= 1'b0;
            frame_done <= 1'b0;
            overrun    <= 1'b0;
            pending    <= 1'b0;
            force_all  <= 1'b1;
            dirty_l    <= 1'b0;
            char_idx   <= '0;
            last_u     <= '0;
            last_l     <= '0;
            for (int unsigned i = 0; i < FRAME_CHARS; i++) begin
                shadow[i]   <= '0;
                pend_buf[i] <= '0;
            end
        end else begin
            overrun <= 1'b0;

            if (state != IDLE && valid_out) begin
                pend_buf <= frame_in;
                pending  <= 1'b1;
                overrun  <= pending;
            end

            case (state)
                IDLE: begin
                    // A fresh input frame takes priority over the buffered one.
                    if (valid_out) begin
                        shadow  <= frame_in;
                        overrun <= pending;
                        pending <= 1'b0;
                        state   <= LOAD;
                    end else if (pending) begin
                        shadow  <= pend_buf;
                        pending <= 1'b0;
                        state   <= LOAD;
                    end
                end

                LOAD: begin
                    dirty_l <= load_dirty_l;
                    if (load_dirty_u) begin
                        state     <= U_CMD;
                        lcd_valid <= 1'b1;
                        lcd_rs    <= RS_CMD;
                        lcd_data  <= CMD_UPPER;
                    end else if (load_dirty_l) begin
                        state     <= L_CMD;
                        lcd_valid <= 1'b1;
                        lcd_rs    <= RS_CMD;
                        lcd_data  <= CMD_LOWER;
                    end else begin
                        state      <= DONE;
                        frame_done <= 1'b1;
                    end
                end

                U_CMD: begin
                    if (accepted) begin
                        state    <= U_CH;
                        char_idx <= '0;
                        lcd_rs   <= RS_DATA;
                        lcd_data <= shadow[0];
                    end
                end

                U_CH: begin
                    if (accepted) begin
                        if (char_idx == 2'd1) begin
                            last_u <= {shadow[0], shadow[1]};
                            if (dirty_l) begin
                                state    <= L_CMD;
                                lcd_rs   <= RS_CMD;
                                lcd_data <= CMD_LOWER;
                            end else begin
                                state      <= DONE;
                                lcd_valid  <= 1'b0;
                                frame_done <= 1'b1;
                            end
                        end else begin
                            char_idx <= char_idx + 2'd1;
                            lcd_data <= shadow[1];
                        end
                    end
                end

                L_CMD: begin
                    if (accepted) begin
                        state    <= L_CH;
                        char_idx <= '0;
                        lcd_rs   <= RS_DATA;
                        lcd_data <= shadow[2];
                    end
                end

                L_CH: begin
                    if (accepted) begin
                        if (char_idx == 2'd3) begin
                            last_l     <= {shadow[2], shadow[3], shadow[4], shadow[5]};
                            state      <= DONE;
                            lcd_valid  <= 1'b0;
                            frame_done <= 1'b1;
                        end else begin
                            char_idx <= char_idx + 2'd1;
                            lcd_data <= shadow[3'd3 + {1'b0, char_idx}];
                        end
                    end
                end

                DONE: begin
                    frame_done <= 1'b0;
                    force_all  <= 1'b0;
                    state      <= IDLE;
                end

                default: state <= IDLE;
            endcase
        end
    end

endmodule

// File: tb/tb_lcd_line_writer.sv
// Self-checking bench for lcd_line_writer: directed scenarios followed by
// randomized frames with random backpressure, checked against a line-level
// reference model that predicts the byte stream per frame.
module tb_lcd_line_writer;

    logic       clock = 1'b0;
    logic       reset = 1'b1;
    logic       valid_out = 1'b0;
    logic [7:0] upper10 = '0, upper01 = '0;
    logic [7:0] lower1000 = '0, lower0100 = '0, lower0010 = '0, lower0001 = '0;
    logic [7:0] lcd_data;
    logic       lcd_rs, lcd_valid;
    logic       lcd_ready = 1'b1;
    logic       busy, frame_done, overrun;

    localparam logic [7:0] CMD_U = 8'h8E;
    localparam logic [7:0] CMD_L = 8'hCC;

    int total = 0;
    int bad   = 0;
    int cyc   = 0;
    int done_cnt = 0;
    int done_cyc = 0;
    int ovr_cnt  = 0;
    int rdy_mode = 0;   // 0: always ready, 1: random, 2: stall 3 cycles on 0x36

    logic [8:0] got_q[$];
    logic [8:0] exp_q[$];

    // reference model state: last line contents written to the display
    logic [15:0] m_u = '0;
    logic [31:0] m_l = '0;
    bit          m_force = 1'b1;

    lcd_line_writer #(.UPPER_POS(7'h0E), .LOWER_POS(7'h4C)) dut (
        .clock(clock), .reset(reset), .valid_out(valid_out),
        .upper10(upper10), .upper01(upper01),
        .lower1000(lower1000), .lower0100(lower0100),
        .lower0010(lower0010), .lower0001(lower0001),
        .lcd_data(lcd_data), .lcd_rs(lcd_rs), .lcd_valid(lcd_valid),
        .lcd_ready(lcd_ready), .busy(busy),
        .frame_done(frame_done), .overrun(overrun)
    );

    always #5 clock = ~clock;

    always @(posedge clock) cyc <= cyc + 1;

    always @(negedge clock) begin
        if (!reset) begin
            if (lcd_valid && lcd_ready) got_q.push_back({lcd_rs, lcd_data});
            if (frame_done) begin
                done_cnt = done_cnt + 1;
                done_cyc = cyc;
            end
            if (overrun) ovr_cnt = ovr_cnt + 1;
        end
    end

    task automatic check(input string tag, input logic [63:0] got, input logic [63:0] exp);
        total = total + 1;
        if (got !== exp) begin
            bad = bad + 1;
            $display("FAIL %s: got=%0h expected=%0h", tag, got, exp);
        end
    endtask

    // Predicts the byte stream for one frame; returns the transfer count.
    function automatic int model_frame(input logic [15:0] u, input logic [31:0] l);
        int n = 0;
        if (m_force || u != m_u) begin
            exp_q.push_back({1'b0, CMD_U});
            exp_q.push_back({1'b1, u[15:8]});
            exp_q.push_back({1'b1, u[7:0]});
            m_u = u;
            n += 3;
        end
        if (m_force || l != m_l) begin
            exp_q.push_back({1'b0, CMD_L});
            for (int i = 3; i >= 0; i--) exp_q.push_back({1'b1, l[i*8 +: 8]});
            m_l = l;
            n += 5;
        end
        m_force = 1'b0;
        return n;
    endfunction

    task automatic pulse(input logic [15:0] u, input logic [31:0] l);
        upper10   = u[15:8];
        upper01   = u[7:0];
        lower1000 = l[31:24];
        lower0100 = l[23:16];
        lower0010 = l[15:8];
        lower0001 = l[7:0];
        valid_out = 1'b1;
        @(posedge clock); #1;
        valid_out = 1'b0;
    endtask

    task automatic wait_done(input int target, input int budget, input string tag);
        for (int i = 0; i < budget && done_cnt < target; i++) begin
            @(posedge clock); #1;
        end
        check({tag, "_done"}, done_cnt, target);
    endtask

    task automatic check_bytes(input string tag);
        check({tag, "_nbytes"}, got_q.size(), exp_q.size());
        for (int i = 0; i < got_q.size() && i < exp_q.size(); i++)
            check({tag, "_byte"}, got_q[i], exp_q[i]);
        got_q.delete();
        exp_q.delete();
    endtask

    task automatic run_frame(input string tag, input logic [15:0] u, input logic [31:0] l,
                             input int extra_lat, input bit chk_lat);
        int c0, n, d0;
        d0 = done_cnt;
        c0 = cyc;
        n  = model_frame(u, l);
        pulse(u, l);
        wait_done(d0 + 1, 300, tag);
        check_bytes(tag);
        if (chk_lat) check({tag, "_lat"}, done_cyc - c0, n + 2 + extra_lat);
    endtask

    // lcd_ready driver
    initial begin
        forever begin
            @(posedge clock); #1;
            case (rdy_mode)
                1: lcd_ready = ($urandom_range(0, 3) != 0);
                2: begin
                    if (lcd_valid && lcd_data == 8'h36) begin
                        lcd_ready = 1'b0;
                        repeat (3) begin
                            @(posedge clock); #1;
                            check("bp_hold", {lcd_valid, lcd_data}, {1'b1, 8'h36});
                        end
                        lcd_ready = 1'b1;
                        rdy_mode  = 0;
                    end else begin
                        lcd_ready = 1'b1;
                    end
                end
                default: lcd_ready = 1'b1;
            endcase
        end
    end

    initial begin
        #200000;
        $display("FAIL watchdog: simulation time limit reached");
        $fatal(1, "watchdog");
    end

    initial begin
        int c0, d0, o0, nD, nR;
        logic [15:0] ru;
        logic [31:0] rl;

        // reset state
        repeat (3) @(posedge clock);
        #1;
        check("reset_outs", {lcd_data, lcd_rs, lcd_valid, busy, frame_done, overrun}, '0);
        reset = 1'b0;
        repeat (2) @(posedge clock);
        #1;

        // full first frame: "69" / "1920"
        c0 = cyc;
        run_frame("full", 16'h3639, 32'h31393230, 0, 1);
        check("full_lat10", done_cyc - c0, 10);

        // identical frame: nothing written
        run_frame("same", 16'h3639, 32'h31393230, 0, 1);

        // lower line only
        run_frame("lower", 16'h3639, 32'h32303330, 0, 1);

        // upper only, then upper back to "69" with 3-cycle stall on 0x36
        run_frame("upper", 16'h3730, 32'h32303330, 0, 1);
        rdy_mode = 2;
        run_frame("bp", 16'h3639, 32'h32303330, 3, 1);
        rdy_mode = 0;

        // overrun: three pulses while busy, only the last is written next
        d0 = done_cnt; o0 = ovr_cnt; c0 = cyc;
        void'(model_frame(16'h3435, 32'h36373839));
        pulse(16'h3435, 32'h36373839);
        @(posedge clock); #1;
        pulse(16'h3131, 32'h31313131);
        @(posedge clock); #1;
        pulse(16'h3232, 32'h32323232);
        @(posedge clock); #1;
        pulse(16'h3833, 32'h30313432);
        nD = model_frame(16'h3833, 32'h30313432);
        wait_done(d0 + 2, 300, "ovr");
        check("ovr_count", ovr_cnt - o0, 2);
        check_bytes("ovr");
        check("ovr_lat", done_cyc - c0, 12 + nD + 1);

        // reset during L_CH with a frame pending
        d0 = done_cnt; o0 = ovr_cnt;
        void'(model_frame(16'h3132, 32'h33343536));
        pulse(16'h3132, 32'h33343536);
        @(posedge clock); #1;
        pulse(16'h3939, 32'h39393939);
        for (int i = 0; i < 50 && got_q.size() < 5; i++) begin
            @(posedge clock); #1;
        end
        check("rst_reached_lch", got_q.size(), 5);
        reset = 1'b1;
        #1;
        check("rst_outs", {lcd_data, lcd_rs, lcd_valid, busy, frame_done, overrun}, '0);
        repeat (2) @(posedge clock);
        #1;
        reset = 1'b0;
        m_force = 1'b1; m_u = '0; m_l = '0;
        got_q.delete(); exp_q.delete();
        repeat (6) @(posedge clock);
        #1;
        check("rst_idle_busy", busy, 1'b0);
        check("rst_pend_lost", got_q.size(), 0);
        check("rst_no_done", done_cnt, d0);
        check("rst_no_ovr", ovr_cnt, o0);
        d0 = done_cnt;
        nR = model_frame(16'h3132, 32'h33343536);
        c0 = cyc;
        pulse(16'h3132, 32'h33343536);
        wait_done(d0 + 1, 300, "rst_again");
        check("rst_again_n8", got_q.size(), 8);
        check_bytes("rst_again");
        check("rst_again_lat", done_cyc - c0, nR + 2);

        // randomized frames with random backpressure
        rdy_mode = 1;
        for (int k = 0; k < 25; k++) begin
            ru = m_u;
            rl = m_l;
            if ($urandom_range(0, 1) != 0)
                ru = {8'h30 + 8'($urandom_range(0, 9)), 8'h30 + 8'($urandom_range(0, 9))};
            if ($urandom_range(0, 1) != 0)
                for (int j = 0; j < 4; j++) rl[j*8 +: 8] = 8'h30 + 8'($urandom_range(0, 9));
            run_frame("rand", ru, rl, 0, 0);
        end
        rdy_mode = 0;

        repeat (3) @(posedge clock);
        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule
